// File: rtl/calc_sequencer.sv
// Calculator sequencer: reads operand pairs from the two SRAM macros, feeds the adder,
// packs two sums per 64-bit buffer word and writes each word back through port 0.
module calc_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr,
  input  logic [DATA_W-1:0] sram_rdata_a,
  input  logic [DATA_W-1:0] sram_rdata_b,
  input  logic [DATA_W-1:0] sum,
  output logic              csb1,
  output logic [ADDR_W-1:0] addr1,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              buf_load,
  output logic              buf_loc,
  output logic              buf_clear,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    ADD   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [ADDR_W-1:0] rd_end_r, rd_end_s;
  logic [ADDR_W-1:0] wr_end_r, wr_end_s;
  logic              half_r, half_s;
  logic              clear_s;
  logic              last_rd_s;
  logic              sum_unused_s;

  // The adder result goes straight into the buffer; the sequencer only times its capture.
  assign sum_unused_s = ^sum;
  assign last_rd_s    = (rd_ptr_r == rd_end_r);

  // Next-state, pointer and buffer-clear decode.
  always_comb begin
    state_s  = state_r;
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    rd_end_s = rd_end_r;
    wr_end_s = wr_end_r;
    half_s   = half_r;
    clear_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          rd_ptr_s = read_start_addr;
          wr_ptr_s = write_start_addr;
          rd_end_s = read_end_addr;
          wr_end_s = write_end_addr;
          half_s   = 1'b0;
          clear_s  = 1'b1;
          if ((read_start_addr > read_end_addr) || (write_start_addr > write_end_addr)) begin
            state_s = DONE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: state_s = WAIT;
      WAIT: state_s = ADD;
      ADD: begin
        if (half_r || last_rd_s) begin
          state_s = WRITE;
        end else begin
          half_s   = 1'b1;
          rd_ptr_s = rd_ptr_r + ADDR_ONE;
          state_s  = READ;
        end
      end
      WRITE: begin
        // End checks run before any increment, so pointers never wrap.
        if (last_rd_s || (wr_ptr_r == wr_end_r)) begin
          state_s = DONE;
        end else begin
          wr_ptr_s = wr_ptr_r + ADDR_ONE;
          rd_ptr_s = rd_ptr_r + ADDR_ONE;
          half_s   = 1'b0;
          clear_s  = 1'b1;
          state_s  = READ;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, pointers and strobes; strobes are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rd_ptr_r  <= ADDR_ZERO;
      wr_ptr_r  <= ADDR_ZERO;
      rd_end_r  <= ADDR_ZERO;
      wr_end_r  <= ADDR_ZERO;
      half_r    <= 1'b0;
      csb1      <= 1'b1;
      addr1     <= ADDR_ZERO;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      addr0     <= ADDR_ZERO;
      buf_load  <= 1'b0;
      buf_loc   <= 1'b0;
      buf_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_ptr_r  <= rd_ptr_s;
      wr_ptr_r  <= wr_ptr_s;
      rd_end_r  <= rd_end_s;
      wr_end_r  <= wr_end_s;
      half_r    <= half_s;
      csb1      <= (state_s != READ);
      addr1     <= (state_s == READ) ? rd_ptr_s : ADDR_ZERO;
      csb0      <= (state_s != WRITE);
      web0      <= (state_s != WRITE);
      addr0     <= (state_s == WRITE) ? wr_ptr_s : ADDR_ZERO;
      buf_load  <= (state_s == ADD);
      buf_loc   <= (state_s == ADD) ? half_s : 1'b0;
      buf_clear <= clear_s;
      busy      <= (state_s != IDLE);
      done      <= (state_s == DONE);
    end
  end

  // Operand capture at the end of WAIT, when the SRAM output is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= DATA_ZERO;
      op_b <= DATA_ZERO;
    end else if (state_r == WAIT) begin
      op_a <= sram_rdata_a;
      op_b <= sram_rdata_b;
    end else begin
      op_a <= op_a;
      op_b <= op_b;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: SRAM, adder and result buffer models around the DUT,
// expected reads/writes/done cycles from a pairwise reference model of each run.
module tb_calc_sequencer;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rsa, rea, wsa, wea;
  logic [DW-1:0] rdata_a, rdata_b, sum;
  logic          csb1, csb0, web0;
  logic [AW-1:0] addr1, addr0;
  logic [DW-1:0] op_a, op_b;
  logic          buf_load, buf_loc, buf_clear, busy, done;

  logic [DW-1:0]   mem_a [DEPTH];
  logic [DW-1:0]   mem_b [DEPTH];
  logic [DW-1:0]   ref_a [DEPTH];
  logic [DW-1:0]   ref_b [DEPTH];
  logic [2*DW-1:0] bufr;
  logic            ld_en;
  logic [AW-1:0]   ld_addr;
  logic [DW-1:0]   ld_a, ld_b;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          rd_q[$];
  int          wa_q[$];
  logic [63:0] wd_q[$];
  int          done_q[$];

  calc_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .read_start_addr(rsa), .read_end_addr(rea),
    .write_start_addr(wsa), .write_end_addr(wea),
    .sram_rdata_a(rdata_a), .sram_rdata_b(rdata_b), .sum(sum),
    .csb1(csb1), .addr1(addr1), .csb0(csb0), .web0(web0), .addr0(addr0),
    .op_a(op_a), .op_b(op_b),
    .buf_load(buf_load), .buf_loc(buf_loc), .buf_clear(buf_clear),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign sum = op_a + op_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-macro SRAM: port 1 read with one-cycle latency, port 0 write of the buffer word.
  always @(posedge clk) begin
    if (csb1 === 1'b0) begin
      rdata_a <= mem_a[addr1];
      rdata_b <= mem_b[addr1];
    end
    if (csb0 === 1'b0 && web0 === 1'b0) begin
      mem_a[addr0] <= bufr[31:0];
      mem_b[addr0] <= bufr[63:32];
    end else if (ld_en) begin
      mem_a[ld_addr] <= ld_a;
      mem_b[ld_addr] <= ld_b;
    end
  end

  // Two-slot result buffer.
  always @(posedge clk) begin
    if (rst === 1'b1 || buf_clear === 1'b1) bufr <= 64'd0;
    else if (buf_load === 1'b1) begin
      if (buf_loc) bufr[63:32] <= sum;
      else         bufr[31:0]  <= sum;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a run is a list of pairs; each pair of reads yields one buffer word written back.
  task automatic model_run(input int rs, input int re, input int ws, input int we, input int c0);
    int rd, wr, nr, nw;
    logic [31:0] lo, hi;
    bit fin;
    if (rs > re || ws > we) begin
      done_q.push_back(c0 + 1);
      return;
    end
    rd = rs; wr = ws; nr = 0; nw = 0; fin = 1'b0;
    while (!fin) begin
      rd_q.push_back(rd);
      lo = ref_a[rd] + ref_b[rd];
      nr++;
      if (rd == re) begin
        hi  = 32'd0;
        fin = 1'b1;
      end else begin
        rd++;
        rd_q.push_back(rd);
        hi  = ref_a[rd] + ref_b[rd];
        nr++;
        fin = (rd == re) || (wr == we);
      end
      wa_q.push_back(wr);
      wd_q.push_back({hi, lo});
      ref_a[wr] = lo;
      ref_b[wr] = hi;
      nw++;
      if (!fin) begin
        wr++;
        rd++;
      end
    end
    done_q.push_back(c0 + 1 + 3 * nr + nw);
  endtask

  task automatic poke(input int a, input logic [31:0] va, input logic [31:0] vb);
    ld_en = 1'b1; ld_addr = AW'(a); ld_a = va; ld_b = vb;
    ref_a[a] = va; ref_b[a] = vb;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_csb0"}, 64'(csb0), 64'(1));
    chk({tag, "_web0"}, 64'(web0), 64'(1));
    chk({tag, "_csb1"}, 64'(csb1), 64'(1));
    chk({tag, "_addr0"}, 64'(addr0), 64'(0));
    chk({tag, "_addr1"}, 64'(addr1), 64'(0));
    chk({tag, "_op_a"}, 64'(op_a), 64'(0));
    chk({tag, "_op_b"}, 64'(op_b), 64'(0));
    chk({tag, "_buf_load"}, 64'(buf_load), 64'(0));
    chk({tag, "_buf_loc"}, 64'(buf_loc), 64'(0));
    chk({tag, "_buf_clear"}, 64'(buf_clear), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  task automatic check_image();
    int nmis;
    nmis = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem_a[i] !== ref_a[i] || mem_b[i] !== ref_b[i]) nmis++;
    chk("mem_image", 64'(nmis), 64'(0));
  endtask

  task automatic run(input int rs, input int re, input int ws, input int we, input bit dup);
    int c0, n;
    bit bad;
    @(posedge clk); #1;
    c0 = cyc;
    model_run(rs, re, ws, we, c0);
    rsa = AW'(rs); rea = AW'(re); wsa = AW'(ws); wea = AW'(we);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bad = (rs > re) || (ws > we);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("csb1_after_start", 64'(csb1), bad ? 64'(1) : 64'(0));
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (dup && n == 2) begin
        start = 1'b1;
        rsa = 9'd0; rea = 9'd0; wsa = 9'd500; wea = 9'd500;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_reached", 64'(done), 64'(1));
    @(posedge clk); #1;
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("reads_drained", 64'(rd_q.size()), 64'(0));
    chk("writes_drained", 64'(wa_q.size()), 64'(0));
    chk("done_drained", 64'(done_q.size()), 64'(0));
    check_image();
  endtask

  // Monitor: every SRAM access and done pulse must match the head of its expectation queue.
  initial begin
    int ea, ed;
    logic [63:0] ew;
    forever begin
      @(negedge clk);
      if (csb0 === 1'b0 && csb1 === 1'b0) begin
        checks++; errors++;
        $display("FAIL port_overlap: both ports selected at cycle %0d", cyc);
      end
      if (csb1 === 1'b0) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr1=%0d while no read expected", addr1);
        end else begin
          ea = rd_q.pop_front();
          chk("read_addr", 64'(addr1), 64'(ea));
        end
      end
      if (csb0 === 1'b0) begin
        if (wa_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr0=%0d while no write expected", addr0);
        end else begin
          ea = wa_q.pop_front();
          ew = wd_q.pop_front();
          chk("write_web0", 64'(web0), 64'(0));
          chk("write_addr", 64'(addr0), 64'(ea));
          chk("write_data", bufr, ew);
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done at cycle %0d", cyc);
        end else begin
          ed = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(ed));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, re, ws, we;
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = 9'd0; ld_a = 32'd0; ld_b = 32'd0;
    rsa = 9'd0; rea = 9'd0; wsa = 9'd0; wea = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    for (int i = 0; i < DEPTH; i++) poke(i, $urandom, $urandom);

    // Four operands into two words, 15-cycle run.
    for (int i = 0; i < 4; i++) poke(i, 32'(i + 1), 32'(10 * (i + 1)));
    run(0, 3, 8, 9, 1'b0);
    chk("tp1_mem_a8", 64'(mem_a[8]), 64'd11);
    chk("tp1_mem_b8", 64'(mem_b[8]), 64'd22);
    chk("tp1_mem_a9", 64'(mem_a[9]), 64'd33);
    chk("tp1_mem_b9", 64'(mem_b[9]), 64'd44);

    // Odd count leaves the upper slot of the last word at zero.
    run(0, 2, 8, 9, 1'b0);
    chk("odd_mem_a9", 64'(mem_a[9]), 64'd33);
    chk("odd_mem_b9", 64'(mem_b[9]), 64'd0);

    // Write range runs out first.
    run(0, 7, 4, 4, 1'b0);
    chk("wrexh_mem_a4", 64'(mem_a[4]), 64'd11);
    chk("wrexh_mem_b4", 64'(mem_b[4]), 64'd22);

    // Carry out of the adder is dropped.
    poke(20, 32'hFFFF_FFFF, 32'd2);
    run(20, 20, 30, 30, 1'b0);
    chk("ovf_mem_a30", 64'(mem_a[30]), 64'd1);
    chk("ovf_mem_b30", 64'(mem_b[30]), 64'd0);

    // Invalid ranges: no access, done right away.
    run(5, 3, 40, 41, 1'b0);
    run(10, 12, 41, 40, 1'b0);

    // Top of the address space, overlapping read and write ranges.
    run(508, 511, 509, 511, 1'b0);

    // Reset while in WAIT.
    @(posedge clk); #1;
    rsa = 9'd0; rea = 9'd3; wsa = 9'd8; wea = 9'd9; start = 1'b1;
    rd_q.push_back(0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midrst");
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_reads_drained", 64'(rd_q.size()), 64'(0));
    chk("midrst_no_done", 64'(done_q.size()), 64'(0));
    check_image();

    // Second start while busy is dropped.
    run(0, 3, 8, 9, 1'b1);

    for (int k = 0; k < 20; k++) begin
      rs = int'($urandom_range(0, 511));
      re = rs + int'($urandom_range(0, 9));
      if (re > 511) re = 511;
      ws = int'($urandom_range(0, 511));
      we = ws + int'($urandom_range(0, 4));
      if (we > 511) we = 511;
      if ($urandom_range(0, 5) == 0 && rs > 0) re = rs - 1;
      run(rs, re, ws, we, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencer for the calculator datapath. Walks a read address range in the two SRAM macros, presents each address's pair of 32-bit words to the 32-bit adder, and steers results into the two-slot result buffer. Writes each full 64-bit buffer back through port 0 to a write address range. Sits between the top level's memory configuration inputs and the SRAMs, adder and result buffer.

## Interface
- ADDR_W, 9: SRAM address width (512 words per macro).
- DATA_W, 32: operand and sum width; one word per macro per address.
- clk  in  1  clock for sequencer, both SRAM ports, and result buffer.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE.
- read_start_addr, read_end_addr  in  ADDR_W  inclusive operand range; sampled on accepted start.
- write_start_addr, write_end_addr  in  ADDR_W  inclusive result range; sampled on accepted start.
- sram_rdata_a, sram_rdata_b  in  DATA_W  port-1 dout of sram_A and sram_B.
- sum  in  DATA_W  adder sum (combinational from op_a/op_b; carry discarded).
- csb1  out  1  port-1 chip select, active low, shared by both macros.
- addr1  out  ADDR_W  port-1 read address.
- csb0, web0  out  1  port-0 chip select / write enable, active low; wmask0 is tied 4'hF at top level.
- addr0  out  ADDR_W  port-0 write address; din0 comes from the result buffer output.
- op_a, op_b  out  DATA_W  registered adder operands.
- buf_load  out  1  result buffer captures sum this cycle.
- buf_loc  out  1  buffer slot: 0 = lower 32 bits, 1 = upper 32 bits.
- buf_clear  out  1  zeroes the buffer this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

## Operation
- States: IDLE, READ, WAIT, ADD, WRITE, DONE. Encode as a state register. Decode all strobes from registered state and pointers only.
- IDLE: on start, latch all four addresses. Set rd_ptr=read_start, wr_ptr=write_start, half=0, and assert buf_clear. If read_start>read_end or write_start>write_end, go to DONE with no memory access. Otherwise go to READ.
- READ: csb1=0, addr1=rd_ptr. Go to WAIT.
- WAIT: SRAM data is valid at the end of this cycle. Register op_a<=sram_rdata_a and op_b<=sram_rdata_b. Go to ADD.
- ADD: buf_load=1, buf_loc=half. last_rd = (rd_ptr==read_end).
  - If half=1 or last_rd, go to WRITE.
  - Otherwise set half<=1, rd_ptr<=rd_ptr+1, and go to READ.
- WRITE: csb0=0, web0=0, addr0=wr_ptr. After a last_rd ADD with half=0, the upper slot is still 0 from the clear.
  - If last_rd or wr_ptr==write_end, go to DONE.
  - Otherwise set wr_ptr+1, rd_ptr+1, half<=0, assert buf_clear, and go to READ.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: sum is modulo 2^DATA_W; overflow is silently dropped. Pointers never wrap because termination checks the end addresses before incrementing.
- Port 0 and port 1 are never active in the same cycle.

## Timing
- Reset: the cycle after rst is sampled high, the block is in IDLE with these outputs:
  - csb0=1, web0=1, csb1=1.
  - addr0=0, addr1=0, op_a=0, op_b=0.
  - buf_load=0, buf_loc=0, buf_clear=0, busy=0, done=0.
- rst overrides start and any in-flight access. A write already launched in the reset cycle completes in the SRAM; no further accesses follow.
- start accepted at edge N: busy=1 and csb1=0 from cycle N+1.
- SRAM read latency is 1 cycle: address in READ, data sampled at the end of WAIT.
- One result is 3 cycles (READ, WAIT, ADD). One write is 7 cycles (two results plus WRITE).
- done asserts the cycle after the final WRITE, or the cycle after start for an invalid range. busy falls the cycle after done.
- start pulses while busy=1 are dropped and not queued.

## Test plan
- Read range 0..3, write range 8..9. A[0..3]=1,2,3,4 and B[0..3]=10,20,30,40 -> mem[8]={B:22,A:11}, mem[9]={B:44,A:33}, done 15 cycles after start.
- Odd count: read range 0..2, write range 8..9 -> mem[9]={B:0, A:A[2]+B[2]}, 2 writes, done pulse.
- Write range exhausted first: read range 0..7, write range 4..4 -> exactly one write to addr 4, reads only at 0 and 1.
- Overflow: A=32'hFFFF_FFFF, B=2 -> buffer slot holds 1, no other effect.
- Invalid range: read_start=5, read_end=3 -> csb0/csb1 stay 1, done the cycle after start.
- Reset mid-run (in WAIT), then a start pulse while busy -> IDLE values the next cycle, no further csb activity, and a start during busy is ignored (single done).
